// File: rtl/rom_port_arbiter_pkg.sv
// Shared types and constants for the instruction-ROM read-port arbiter.
// Latency: n/a (types and constants only).
// Backpressure: n/a.
package rom_port_arbiter_pkg;

  // ROM geometry, shared with the ROM macro wrapper.
  localparam int ROM_DEPTH_WORDS = 128;

  typedef enum logic {
    OWN_IF,
    OWN_LD
  } rom_owner_e;

  typedef enum logic [1:0] {
    IDLE,  // nothing in flight
    WAIT,  // ROM read (or error response) returning this cycle
    HOLD   // response parked in the hold register
  } arb_state_e;

endpackage

// File: rtl/rom_port_arbiter_prio_arb.sv
// Fixed-priority (LD first) grant with an IF anti-starvation counter.
// Latency: combinational grants; the counter updates on the clock edge.
// Backpressure: grants only when can_issue; the counter is frozen otherwise.
//
// Ports:
//   clk, rst_n          clock, async active-low reset
//   if_vld, ld_vld      request valids from fetch and load ports
//   can_issue           the response path can accept a new request this cycle
//   grant_if, grant_ld  one-hot (or zero) grant
module rom_prio_arb #(
  parameter int STARVE_MAX = 4
) (
  input  logic clk,
  input  logic rst_n,
  input  logic if_vld,
  input  logic ld_vld,
  input  logic can_issue,
  output logic grant_if,
  output logic grant_ld
);

  localparam int CNT_W = $clog2(STARVE_MAX + 1);

  logic [CNT_W-1:0] starve_cnt;
  logic             starved;

  assign starved = (starve_cnt == CNT_W'(STARVE_MAX));

  // IF wins when alone, or when it has lost STARVE_MAX times in a row.
  always_comb begin
    grant_if = can_issue && if_vld && (!ld_vld || starved);
    grant_ld = can_issue && ld_vld && !grant_if;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      starve_cnt <= '0;
    end else if (can_issue) begin
      if (grant_if) begin
        starve_cnt <= '0;
      end else if (if_vld && !starved) begin
        starve_cnt <= starve_cnt + CNT_W'(1);
      end
    end
  end

endmodule

// File: rtl/rom_port_arbiter.sv
// Shares the 1-cycle synchronous ROM read port between fetch (IF) and load (LD).
// Latency: response valid exactly one cycle after the request handshake.
// Backpressure: response parks in a hold register; no new grant until the owner accepts it.
//
// Ports:
//   clk, rst_n                          clock, async active-low reset
//   if_req_valid/ready/addr             IF byte-address request
//   if_rsp_valid/ready/data/err         IF response (err: misaligned or out of range)
//   ld_req_*, ld_rsp_*                  same for the LD port
//   rom_en, rom_addr, rom_rdata         ROM read port (data valid the cycle after rom_en)
module rom_port_arbiter
  import rom_port_arbiter_pkg::*;
#(
  parameter int ADDR_W      = 32,
  parameter int DEPTH_WORDS = ROM_DEPTH_WORDS,
  parameter int STARVE_MAX  = 4,
  localparam int IDX_W      = $clog2(DEPTH_WORDS)
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              if_req_valid,
  output logic              if_req_ready,
  input  logic [ADDR_W-1:0] if_req_addr,
  output logic              if_rsp_valid,
  input  logic              if_rsp_ready,
  output logic [31:0]       if_rsp_data,
  output logic              if_rsp_err,
  input  logic              ld_req_valid,
  output logic              ld_req_ready,
  input  logic [ADDR_W-1:0] ld_req_addr,
  output logic              ld_rsp_valid,
  input  logic              ld_rsp_ready,
  output logic [31:0]       ld_rsp_data,
  output logic              ld_rsp_err,
  output logic              rom_en,
  output logic [IDX_W-1:0]  rom_addr,
  input  logic [31:0]       rom_rdata
);

  arb_state_e       state_q, state_d;
  rom_owner_e       owner_q, owner_d;
  logic             err_q, err_d;
  logic [31:0]      hold_q, hold_d;
  logic [IDX_W-1:0] addr_q;

  logic              rsp_vld;
  logic [31:0]       cur_data;
  logic              own_rdy;
  logic              accept;
  logic              can_issue;
  logic              grant_if, grant_ld, issue;
  logic [ADDR_W-1:0] sel_addr;
  logic              sel_err;

  // Response path: live ROM data in WAIT (zeroed for errors), parked copy in HOLD.
  assign rsp_vld  = (state_q != IDLE);
  assign cur_data = (state_q == HOLD) ? hold_q : (err_q ? 32'd0 : rom_rdata);
  assign own_rdy  = (owner_q == OWN_IF) ? if_rsp_ready : ld_rsp_ready;
  assign accept   = rsp_vld && own_rdy;

  // Gating with rst_n keeps req_ready/rom_en low while reset is held.
  assign can_issue = rst_n && ((state_q == IDLE) || accept);

  rom_prio_arb #(
    .STARVE_MAX (STARVE_MAX)
  ) u_prio (
    .clk       (clk),
    .rst_n     (rst_n),
    .if_vld    (if_req_valid),
    .ld_vld    (ld_req_valid),
    .can_issue (can_issue),
    .grant_if  (grant_if),
    .grant_ld  (grant_ld)
  );

  assign issue    = grant_if || grant_ld;
  assign sel_addr = grant_if ? if_req_addr : ld_req_addr;
  assign sel_err  = (sel_addr[1:0] != 2'b00) ||
                    (sel_addr[ADDR_W-1:2] >= (ADDR_W-2)'(DEPTH_WORDS));

  assign if_req_ready = grant_if;
  assign ld_req_ready = grant_ld;

  // Errored requests never touch the ROM; rom_addr keeps its previous value then.
  assign rom_en   = issue && !sel_err;
  assign rom_addr = rom_en ? sel_addr[2 +: IDX_W] : addr_q;

  always_comb begin
    if_rsp_valid = rsp_vld && (owner_q == OWN_IF);
    ld_rsp_valid = rsp_vld && (owner_q == OWN_LD);
    if_rsp_data  = if_rsp_valid ? cur_data : 32'd0;
    ld_rsp_data  = ld_rsp_valid ? cur_data : 32'd0;
    if_rsp_err   = if_rsp_valid && err_q;
    ld_rsp_err   = ld_rsp_valid && err_q;
  end

  always_comb begin
    state_d = state_q;
    owner_d = owner_q;
    err_d   = err_q;
    hold_d  = hold_q;
    if (issue) begin
      // Issue only happens from IDLE or alongside an accept, so nothing is dropped.
      state_d = WAIT;
      owner_d = grant_if ? OWN_IF : OWN_LD;
      err_d   = sel_err;
    end else begin
      case (state_q)
        WAIT: begin
          if (accept) begin
            state_d = IDLE;
          end else begin
            // ROM output is only valid for one cycle; park it.
            state_d = HOLD;
            hold_d  = cur_data;
          end
        end
        HOLD: begin
          if (accept) begin
            state_d = IDLE;
          end
        end
        default: state_d = state_q;
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      owner_q <= OWN_IF;
      err_q   <= 1'b0;
      hold_q  <= '0;
      addr_q  <= '0;
    end else begin
      state_q <= state_d;
      owner_q <= owner_d;
      err_q   <= err_d;
      hold_q  <= hold_d;
      if (rom_en) begin
        addr_q <= rom_addr;
      end
    end
  end

endmodule

// File: tb/tb_rom_port_arbiter.sv
// Self-checking bench for rom_port_arbiter: directed scenarios with literal
// expectations, then randomized traffic against a transaction-level model.
module tb_rom_port_arbiter;

  localparam int SMAX  = 4;
  localparam int DEPTH = 128;

  logic        clk = 1'b0;
  logic        rst_n = 1'b1;
  logic        if_req_valid = 1'b0, ld_req_valid = 1'b0;
  logic        if_req_ready, ld_req_ready;
  logic [31:0] if_req_addr = '0, ld_req_addr = '0;
  logic        if_rsp_valid, ld_rsp_valid;
  logic        if_rsp_ready = 1'b0, ld_rsp_ready = 1'b0;
  logic [31:0] if_rsp_data, ld_rsp_data;
  logic        if_rsp_err, ld_rsp_err;
  logic        rom_en;
  logic [6:0]  rom_addr;
  logic [31:0] rom_rdata = '0;

  logic [31:0] mem [DEPTH];

  int n_total = 0;
  int n_pass  = 0;

  rom_port_arbiter #(.ADDR_W(32), .DEPTH_WORDS(DEPTH), .STARVE_MAX(SMAX)) dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .if_req_valid (if_req_valid),
    .if_req_ready (if_req_ready),
    .if_req_addr  (if_req_addr),
    .if_rsp_valid (if_rsp_valid),
    .if_rsp_ready (if_rsp_ready),
    .if_rsp_data  (if_rsp_data),
    .if_rsp_err   (if_rsp_err),
    .ld_req_valid (ld_req_valid),
    .ld_req_ready (ld_req_ready),
    .ld_req_addr  (ld_req_addr),
    .ld_rsp_valid (ld_rsp_valid),
    .ld_rsp_ready (ld_rsp_ready),
    .ld_rsp_data  (ld_rsp_data),
    .ld_rsp_err   (ld_rsp_err),
    .rom_en       (rom_en),
    .rom_addr     (rom_addr),
    .rom_rdata    (rom_rdata)
  );

  always #5 clk = ~clk;

  // ROM: one-cycle synchronous read.
  always @(posedge clk) begin
    if (rom_en) rom_rdata <= mem[rom_addr];
  end

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_total++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %h want %h at %0t", nm, act, exp, $time);
  endtask

  // ---------------- transaction-level model, checked every cycle ----------------
  bit          m_vld;
  bit          m_is_ld;
  logic [31:0] m_data;
  bit          m_err;
  int          m_starve;
  int          m_last_idx;

  always @(negedge clk) begin
    if (!rst_n) begin
      chk("rst_if_rsp_valid", 32'(if_rsp_valid), 0);
      chk("rst_ld_rsp_valid", 32'(ld_rsp_valid), 0);
      chk("rst_if_req_ready", 32'(if_req_ready), 0);
      chk("rst_ld_req_ready", 32'(ld_req_ready), 0);
      chk("rst_rom_en", 32'(rom_en), 0);
      chk("rst_rom_addr", 32'(rom_addr), 0);
      m_vld = 0; m_is_ld = 0; m_data = '0; m_err = 0; m_starve = 0; m_last_idx = 0;
    end else begin
      bit          accept, can, win_if, win_ld, a_err, exp_en;
      logic [31:0] a;
      int          idx;
      accept = m_vld && (m_is_ld ? ld_rsp_ready : if_rsp_ready);
      can    = !m_vld || accept;
      win_if = 0; win_ld = 0;
      if (can) begin
        if (if_req_valid && ld_req_valid) begin
          if (m_starve == SMAX) win_if = 1; else win_ld = 1;
        end else if (if_req_valid) win_if = 1;
        else if (ld_req_valid) win_ld = 1;
      end
      a      = win_if ? if_req_addr : ld_req_addr;
      a_err  = (a % 4 != 0) || (a / 4 >= DEPTH);
      idx    = int'((a / 4) % DEPTH);
      exp_en = (win_if || win_ld) && !a_err;

      chk("if_rsp_valid", 32'(if_rsp_valid), 32'(m_vld && !m_is_ld));
      chk("ld_rsp_valid", 32'(ld_rsp_valid), 32'(m_vld && m_is_ld));
      chk("if_rsp_data", if_rsp_data, (m_vld && !m_is_ld) ? m_data : 32'd0);
      chk("ld_rsp_data", ld_rsp_data, (m_vld && m_is_ld) ? m_data : 32'd0);
      chk("if_rsp_err", 32'(if_rsp_err), 32'(m_vld && !m_is_ld && m_err));
      chk("ld_rsp_err", 32'(ld_rsp_err), 32'(m_vld && m_is_ld && m_err));
      chk("if_req_ready", 32'(if_req_ready), 32'(win_if));
      chk("ld_req_ready", 32'(ld_req_ready), 32'(win_ld));
      chk("rom_en", 32'(rom_en), 32'(exp_en));
      chk("rom_addr", 32'(rom_addr), exp_en ? 32'(idx) : 32'(m_last_idx));

      if (win_if || win_ld) begin
        m_vld   = 1;
        m_is_ld = win_ld;
        m_err   = a_err;
        m_data  = a_err ? 32'd0 : mem[idx];
      end else if (accept) begin
        m_vld = 0;
      end
      if (can) begin
        if (win_if) m_starve = 0;
        else if (if_req_valid && m_starve < SMAX) m_starve++;
      end
      if (exp_en) m_last_idx = idx;
    end
  end

  // ---------------- directed + random stimulus ----------------
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic mid();
    @(negedge clk);
  endtask

  function automatic logic [31:0] rand_addr();
    int r;
    r = $urandom_range(0, 9);
    if (r <= 6) return {23'd0, 7'($urandom_range(0, DEPTH - 1)), 2'b00};
    if (r == 7) return {23'd0, 7'($urandom_range(0, DEPTH - 1)), 2'($urandom_range(1, 3))};
    if (r == 8) return 32'($urandom_range(DEPTH, DEPTH + 64)) << 2;
    return $urandom();
  endfunction

  initial begin
    for (int i = 0; i < DEPTH; i++) mem[i] = {8'hD0, 8'(i * 37), 8'(~i), 8'(i)};

    // Reset, with a request presented that must not be accepted.
    #1 rst_n = 1'b0;
    if_req_valid = 1'b1;
    tick();
    #2;
    chk("lit_rst_if_req_ready", 32'(if_req_ready), 0);
    chk("lit_rst_rom_en", 32'(rom_en), 0);
    chk("lit_rst_if_rsp_valid", 32'(if_rsp_valid), 0);
    if_req_valid = 1'b0;
    tick();
    rst_n = 1'b1;
    if_rsp_ready = 1'b1;
    ld_rsp_ready = 1'b1;

    // IF-only stream 0x0, 0x4, 0x8.
    begin
      logic [31:0] exp_d [3];
      exp_d[0] = 32'hD000FF00; exp_d[1] = 32'hD025FE01; exp_d[2] = 32'hD04AFD02;
      for (int k = 0; k < 4; k++) begin
        tick();
        if_req_valid = (k < 3);
        if_req_addr  = 32'(4 * k);
        mid();
        if (k < 3) chk("lit_stream_ready", 32'(if_req_ready), 1);
        if (k > 0) chk("lit_stream_data", if_rsp_data, exp_d[k-1]);
      end
      tick();
      mid();
      chk("lit_stream_idle", 32'(if_rsp_valid), 0);
    end

    // Contention: grants LD,LD,LD,LD,IF repeating.
    for (int k = 0; k < 10; k++) begin
      tick();
      if_req_valid = 1'b1; if_req_addr = 32'h20;
      ld_req_valid = 1'b1; ld_req_addr = 32'h40;
      mid();
      chk("lit_contend_if_grant", 32'(if_req_ready), 32'((k % 5) == 4));
      chk("lit_contend_ld_grant", 32'(ld_req_ready), 32'((k % 5) != 4));
    end
    tick();
    if_req_valid = 1'b0; ld_req_valid = 1'b0;
    tick();

    // Back-pressure on LD at 0x10 while IF waits.
    ld_req_valid = 1'b1; ld_req_addr = 32'h10; ld_rsp_ready = 1'b0;
    mid();
    chk("lit_bp_ld_grant", 32'(ld_req_ready), 1);
    for (int c = 0; c < 4; c++) begin
      tick();
      ld_req_valid = 1'b0;
      if_req_valid = 1'b1; if_req_addr = 32'h0;
      ld_rsp_ready = (c == 3);
      mid();
      chk("lit_bp_ld_valid", 32'(ld_rsp_valid), 1);
      chk("lit_bp_ld_data", ld_rsp_data, 32'hD094FB04);
      chk("lit_bp_if_stall", 32'(if_req_ready), 32'(c == 3));
    end
    tick();
    if_req_valid = 1'b0;
    mid();
    chk("lit_bp_ld_done", 32'(ld_rsp_valid), 0);
    chk("lit_bp_if_data", if_rsp_data, 32'hD000FF00);

    // Errors: misaligned IF, out-of-range LD.
    tick();
    if_req_valid = 1'b1; if_req_addr = 32'h6;
    mid();
    chk("lit_err_if_ready", 32'(if_req_ready), 1);
    chk("lit_err_if_rom_en", 32'(rom_en), 0);
    tick();
    if_req_valid = 1'b0;
    ld_req_valid = 1'b1; ld_req_addr = 32'h200;
    mid();
    chk("lit_err_if_err", 32'(if_rsp_err), 1);
    chk("lit_err_if_data", if_rsp_data, 0);
    chk("lit_err_ld_rom_en", 32'(rom_en), 0);
    tick();
    ld_req_valid = 1'b0;
    mid();
    chk("lit_err_ld_valid", 32'(ld_rsp_valid), 1);
    chk("lit_err_ld_err", 32'(ld_rsp_err), 1);

    // Owner routing: LD then IF on consecutive cycles.
    tick();
    ld_req_valid = 1'b1; ld_req_addr = 32'h8;
    tick();
    ld_req_valid = 1'b0;
    if_req_valid = 1'b1; if_req_addr = 32'hC;
    mid();
    chk("lit_route_ld_valid", 32'(ld_rsp_valid), 1);
    chk("lit_route_ld_data", ld_rsp_data, 32'hD04AFD02);
    chk("lit_route_if_quiet", 32'(if_rsp_valid), 0);
    tick();
    if_req_valid = 1'b0;
    mid();
    chk("lit_route_if_data", if_rsp_data, 32'hD06FFC03);
    chk("lit_route_ld_quiet", 32'(ld_rsp_valid), 0);

    // Reset in the middle of an LD issue cycle.
    tick();
    ld_req_valid = 1'b1; ld_req_addr = 32'h14;
    mid();
    #1 rst_n = 1'b0;
    #1;
    chk("lit_midrst_ld_ready", 32'(ld_req_ready), 0);
    chk("lit_midrst_ld_valid", 32'(ld_rsp_valid), 0);
    ld_req_valid = 1'b0;
    tick();
    tick();
    rst_n = 1'b1;
    mid();
    chk("lit_midrst_no_stale", 32'(ld_rsp_valid), 0);
    tick();
    ld_req_valid = 1'b1; ld_req_addr = 32'h18;
    tick();
    ld_req_valid = 1'b0;
    mid();
    chk("lit_midrst_new_data", ld_rsp_data, 32'hD0DEF906);

    // Randomized traffic; the model process does all checking.
    for (int n = 0; n < 3000; n++) begin
      tick();
      if_req_valid = ($urandom_range(0, 3) != 0);
      ld_req_valid = ($urandom_range(0, 2) != 0);
      if_req_addr  = rand_addr();
      ld_req_addr  = rand_addr();
      if_rsp_ready = ($urandom_range(0, 3) != 0);
      ld_rsp_ready = ($urandom_range(0, 3) != 0);
    end
    tick();
    if_req_valid = 1'b0; ld_req_valid = 1'b0;
    if_rsp_ready = 1'b1; ld_rsp_ready = 1'b1;
    repeat (3) tick();
    mid();

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
